// File: rtl/dcmac_0_mac_rx_stats_tdm_gen.sv
// dcmac_0_mac_rx_stats_tdm_gen
// Per-port RX statistics TDM generator. It buffers one 79-bit stats vector
// per channel in a small FIFO and arbitrates round-robin across channels.
// It emits one (valid, id, stats) word per cycle from an output register.
// Counter-clear requests (i_clr) are registered to o_ts_rst/o_ts_rst_id in
// the same output stage. The cleared channel is flushed and masked in the
// request cycle.
// Optional: define DCMAC_0_RX_STATS_TDM_DROP_CNT_EN to add o_drop_cnt, a
// saturating count of dropped samples that is cleared by any i_clr.
module dcmac_0_mac_rx_stats_tdm_gen #(
    parameter int unsigned NUM_CH     = 6,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 stats_clk,
    input  logic                 stats_rst,
    input  logic [NUM_CH-1:0]    i_ch_valid,
    input  logic [NUM_CH*79-1:0] i_ch_stats,
    input  logic                 i_clr,
    input  logic [5:0]           i_clr_id,
    output logic                 o_tdm_stats_valid,
    output logic [5:0]           o_tdm_stats_id,
    output logic [78:0]          o_tdm_stats,
    output logic                 o_ts_rst,
    output logic [5:0]           o_ts_rst_id
`ifdef DCMAC_0_RX_STATS_TDM_DROP_CNT_EN
    ,
    output logic [31:0]          o_drop_cnt
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Per-channel FIFO storage and bookkeeping
    logic [78:0]      mem_q    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [CNT_W-1:0] cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] drop_flag_q, drop_flag_d;

    logic [5:0] rr_ptr_q, rr_ptr_d;

    // Per-cycle control
    logic [NUM_CH-1:0] clr_hit, req, pop, push, drop;
    logic              gnt_found;
    logic [5:0]        gnt_id;
    logic [78:0]       gnt_data;

    // Output stage
    logic        valid_q, valid_d;
    logic [5:0]  id_q, id_d;
    logic [78:0] stats_q, stats_d;
    logic        ts_rst_q, ts_rst_d;
    logic [5:0]  ts_rst_id_q, ts_rst_id_d;

    // Clear masking and round-robin grant search from rr_ptr upward
    always_comb begin
        clr_hit   = '0;
        req       = '0;
        pop       = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_data  = '0;
        rr_ptr_d  = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            clr_hit[k] = i_clr && (i_clr_id == 6'(k));
            req[k]     = (cnt_q[k] != '0) && !clr_hit[k];
        end
        // Split search avoids a modulo index: first rr_ptr..NUM_CH-1, then wrap.
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!gnt_found && req[k] && (k >= 32'(rr_ptr_q))) begin
                gnt_found = 1'b1;
                gnt_id    = 6'(k);
            end
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!gnt_found && req[k] && (k < 32'(rr_ptr_q))) begin
                gnt_found = 1'b1;
                gnt_id    = 6'(k);
            end
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (gnt_found && (gnt_id == 6'(k))) begin
                pop[k]   = 1'b1;
                gnt_data = mem_q[k][rd_ptr_q[k]];
                gnt_data[0] = gnt_data[0] | drop_flag_q[k];
                rr_ptr_d = (k + 1 == NUM_CH) ? 6'd0 : 6'(k + 1);
            end
        end
    end

    // Push/drop decisions and per-channel next state
    always_comb begin
        push        = '0;
        drop        = '0;
        drop_flag_d = drop_flag_q;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            rd_ptr_d[k] = rd_ptr_q[k];
            wr_ptr_d[k] = wr_ptr_q[k];
            cnt_d[k]    = cnt_q[k];
            if (i_ch_valid[k] && !clr_hit[k]) begin
                if ((cnt_q[k] < DEPTH_C) || pop[k]) begin
                    push[k] = 1'b1;
                end else begin
                    drop[k] = 1'b1;
                end
            end
            if (clr_hit[k]) begin
                rd_ptr_d[k]    = '0;
                wr_ptr_d[k]    = '0;
                cnt_d[k]       = '0;
                drop_flag_d[k] = 1'b0;
            end else begin
                if (push[k]) begin
                    wr_ptr_d[k] = wr_ptr_q[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
                end
                if (push[k] && !pop[k]) begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end else if (pop[k] && !push[k]) begin
                    cnt_d[k] = cnt_q[k] - 1'b1;
                end
                if (drop[k]) begin
                    drop_flag_d[k] = 1'b1;
                end else if (pop[k]) begin
                    drop_flag_d[k] = 1'b0;
                end
            end
        end
    end

    // Output stage next values; idle cycles carry zero id/stats
    always_comb begin
        valid_d     = gnt_found;
        id_d        = gnt_found ? gnt_id : '0;
        stats_d     = gnt_found ? gnt_data : '0;
        ts_rst_d    = i_clr;
        ts_rst_id_d = i_clr ? i_clr_id : '0;
    end

    // FIFO payload write (no reset needed; validity is tracked by cnt_q)
    always_ff @(posedge stats_clk) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= i_ch_stats[79*k +: 79];
            end
        end
    end

    // Control state and output registers
    always_ff @(posedge stats_clk) begin
        if (stats_rst) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                rd_ptr_q[k] <= '0;
                wr_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            drop_flag_q <= '0;
            rr_ptr_q    <= '0;
            valid_q     <= 1'b0;
            id_q        <= '0;
            stats_q     <= '0;
            ts_rst_q    <= 1'b0;
            ts_rst_id_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                rd_ptr_q[k] <= rd_ptr_d[k];
                wr_ptr_q[k] <= wr_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            drop_flag_q <= drop_flag_d;
            rr_ptr_q    <= rr_ptr_d;
            valid_q     <= valid_d;
            id_q        <= id_d;
            stats_q     <= stats_d;
            ts_rst_q    <= ts_rst_d;
            ts_rst_id_q <= ts_rst_id_d;
        end
    end

    assign o_tdm_stats_valid = valid_q;
    assign o_tdm_stats_id    = id_q;
    assign o_tdm_stats       = stats_q;
    assign o_ts_rst          = ts_rst_q;
    assign o_ts_rst_id       = ts_rst_id_q;

`ifdef DCMAC_0_RX_STATS_TDM_DROP_CNT_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic [6:0]  drop_num;
    logic [32:0] drop_sum;

    // Saturating drop counter; any clear request zeroes it
    always_comb begin
        drop_num = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            drop_num = drop_num + 7'(drop[k]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + 33'(drop_num);
        drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
        if (i_clr) begin
            drop_cnt_d = '0;
        end
    end

    // Drop counter register
    always_ff @(posedge stats_clk) begin
        if (stats_rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dcmac_0_mac_rx_stats_tdm_gen.sv
// Testbench for dcmac_0_mac_rx_stats_tdm_gen: directed phases plus random
// traffic, every output compared each cycle against a queue-based model.
module tb_dcmac_0_mac_rx_stats_tdm_gen;

    localparam int N = 6;
    localparam int D = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     v;
    logic [N*79-1:0]  st;
    logic             clr;
    logic [5:0]       clr_id;
    logic             o_valid;
    logic [5:0]       o_id;
    logic [78:0]      o_stats;
    logic             o_rst;
    logic [5:0]       o_rst_id;
`ifdef DCMAC_0_RX_STATS_TDM_DROP_CNT_EN
    logic [31:0]      o_dcnt;
`endif

    always #5 clk = ~clk;

    dcmac_0_mac_rx_stats_tdm_gen #(.NUM_CH(N), .FIFO_DEPTH(D)) dut (
        .stats_clk         (clk),
        .stats_rst         (rst),
        .i_ch_valid        (v),
        .i_ch_stats        (st),
        .i_clr             (clr),
        .i_clr_id          (clr_id),
        .o_tdm_stats_valid (o_valid),
        .o_tdm_stats_id    (o_id),
        .o_tdm_stats       (o_stats),
        .o_ts_rst          (o_rst),
        .o_ts_rst_id       (o_rst_id)
`ifdef DCMAC_0_RX_STATS_TDM_DROP_CNT_EN
        ,
        .o_drop_cnt        (o_dcnt)
`endif
    );

    // Reference model state
    logic [78:0] mq [N][$];
    bit          mflag [N];
    int          rr;
    longint      mdrops;
    logic        e_valid;
    logic [5:0]  e_id;
    logic [78:0] e_stats;
    logic        e_rst;
    logic [5:0]  e_rst_id;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [78:0] got, input logic [78:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advances the model by one clock using the inputs currently applied
    task automatic model_step();
        int c;
        bit g;
        logic [78:0] w;
        e_valid = 1'b0; e_id = '0; e_stats = '0;
        e_rst = 1'b0; e_rst_id = '0;
        if (rst) begin
            for (int k = 0; k < N; k++) begin mq[k].delete(); mflag[k] = 0; end
            rr = 0; mdrops = 0;
            return;
        end
        g = 0;
        for (int off = 0; off < N && !g; off++) begin
            c = (rr + off) % N;
            if (mq[c].size() > 0 && !(clr && int'(clr_id) == c)) g = 1;
        end
        if (g) begin
            w = mq[c].pop_front();
            w[0] = w[0] | mflag[c];
            mflag[c] = 0;
            e_valid = 1'b1; e_id = 6'(c); e_stats = w;
            rr = (c + 1) % N;
        end
        for (int k = 0; k < N; k++) begin
            if (v[k] && !(clr && int'(clr_id) == k)) begin
                if (mq[k].size() < D) mq[k].push_back(st[79*k +: 79]);
                else begin mflag[k] = 1; mdrops++; end
            end
        end
        if (clr) begin
            e_rst = 1'b1; e_rst_id = clr_id;
            if (int'(clr_id) < N) begin mq[clr_id].delete(); mflag[clr_id] = 0; end
            mdrops = 0;
        end
        if (mdrops > 64'hFFFF_FFFF) mdrops = 64'hFFFF_FFFF;
    endtask

    function automatic logic [78:0] rnd79();
        return {15'($urandom), $urandom, $urandom};
    endfunction

    // Apply one cycle of inputs, step the model, compare after the edge
    task automatic cyc(input logic r, input logic [N-1:0] vv, input logic c, input logic [5:0] cid);
        rst = r; v = vv; clr = c; clr_id = cid;
        for (int k = 0; k < N; k++) st[79*k +: 79] = rnd79();
        model_step();
        @(posedge clk); #1;
        check_eq("valid",     79'(o_valid),  79'(e_valid));
        check_eq("id",        79'(o_id),     79'(e_id));
        check_eq("stats",     o_stats,       e_stats);
        check_eq("ts_rst",    79'(o_rst),    79'(e_rst));
        check_eq("ts_rst_id", 79'(o_rst_id), 79'(e_rst_id));
`ifdef DCMAC_0_RX_STATS_TDM_DROP_CNT_EN
        check_eq("drop_cnt",  79'(o_dcnt),   79'(mdrops));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; v = '0; clr = 1'b0; clr_id = '0; st = '0;
        cyc(1'b1, '0, 1'b0, '0);
        cyc(1'b1, '0, 1'b0, '0);
        idle(8);

        // Single sample on ch 3 with a fixed payload
        rst = 1'b0; v = 6'b001000; clr = 1'b0; clr_id = '0;
        st = '0; st[79*3 +: 79] = 79'h1234;
        model_step();
        @(posedge clk); #1;
        idle(1);
        check_eq("single_valid", 79'(o_valid), 79'd1);
        check_eq("single_id",    79'(o_id),    79'd3);
        check_eq("single_stats", o_stats,      79'h1234);
        idle(3);

        // All channels once: ids in round-robin order
        cyc(1'b0, '1, 1'b0, '0);
        idle(8);

        // Ch 0 five cycles in a row, no drops expected
        for (int i = 0; i < 5; i++) cyc(1'b0, 6'b000001, 1'b0, '0);
        idle(4);

        // Ch 1 and ch 2 contend: drops, flagged word, then flag cleared
        for (int i = 0; i < 4; i++) cyc(1'b0, 6'b000110, 1'b0, '0);
        idle(4);
        cyc(1'b0, 6'b000010, 1'b0, '0);
        idle(4);

        // Ch 4 holds entries, then clear id 4 with a push in the same cycle
        cyc(1'b0, '1, 1'b0, '0);
        cyc(1'b0, '1, 1'b0, '0);
        cyc(1'b0, 6'b010000, 1'b1, 6'd4);
        idle(10);

        // Clear of an out-of-range id affects no channel
        cyc(1'b0, '1, 1'b1, 6'd63);
        idle(8);

        // Reset with full FIFOs discards buffered samples
        for (int i = 0; i < 3; i++) cyc(1'b0, '1, 1'b0, '0);
        cyc(1'b1, '0, 1'b0, '0);
        cyc(1'b0, 6'b100000, 1'b0, '0);
        idle(4);

        // Random traffic with varying density, clears and rare resets
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] rv;
            int dens;
            dens = (i / 500) % 4;
            rv = '0;
            for (int k = 0; k < N; k++) rv[k] = ($urandom_range(0, 7) < dens * 2);
            cyc(($urandom_range(0, 399) == 0), rv,
                ($urandom_range(0, 9) == 0), 6'($urandom_range(0, 7)));
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
